// File: rtl/proc_ctrl_pkg.sv
// Control-unit operation encodings shared by the PC incrementer and the return stack.
package proc_ctrl_pkg;
  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_LOAD = 2'b01;
  localparam logic [1:0] CTRL_PUSH = 2'b01;
  localparam logic [1:0] CTRL_INCR = 2'b10;
  localparam logic [1:0] CTRL_POP  = 2'b10;
  localparam logic [1:0] CTRL_CLR  = 2'b11;
endpackage

// File: rtl/ret_stack_if.sv
// Operation/status bundle between the control unit (master) and the return stack (slave).
interface ret_stack_if #(
  parameter int n     = 8,
  parameter int depth = 4
);
  localparam int cw = $clog2(depth + 1);

  logic [1:0]    ctrl;
  logic [n-1:0]  in;
  logic [n-1:0]  top;
  logic [cw-1:0] count;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          unf;

  modport master (output ctrl, in, input top, count, empty, full, ovf, unf);
  modport slave  (input ctrl, in, output top, count, empty, full, ovf, unf);
endinterface

// File: rtl/ret_stack_lifo_mem.sv
// Unreset depth x n register array: one synchronous write port, one combinational read port.
module lifo_mem #(
  parameter int n     = 8,
  parameter int depth = 4,
  localparam int aw   = $clog2(depth)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [n-1:0]  wdata,
  input  logic [aw-1:0] raddr,
  output logic [n-1:0]  rdata
);
  logic [n-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ret_stack.sv
// Return-address stack: saturating LIFO with registered top-of-stack and sticky ovf/unf flags.
module ret_stack
  import proc_ctrl_pkg::*;
#(
  parameter int n     = 8,
  parameter int depth = 4
) (
  input  logic         clk,
  input  logic         clr,
  ret_stack_if.slave   bus
);
  localparam int cw = $clog2(depth + 1);
  localparam int aw = $clog2(depth);

  logic [cw-1:0] count_q;
  logic [n-1:0]  top_q;
  logic          ovf_q;
  logic          unf_q;
  logic          empty_w;
  logic          full_w;
  logic          we;
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic [n-1:0]  rd_data;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == cw'(depth));

  // Write lands at entry[count]; on a pop the new top is entry[count-2].
  assign we     = !clr && (bus.ctrl == CTRL_PUSH) && !full_w;
  assign wr_ptr = aw'(count_q);
  assign rd_ptr = aw'(count_q - cw'(2));

  lifo_mem #(.n(n), .depth(depth)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (bus.in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      case (bus.ctrl)
        CTRL_PUSH: begin
          if (!full_w) begin
            count_q <= count_q + cw'(1);
            top_q   <= bus.in;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        CTRL_POP: begin
          if (!empty_w) begin
            count_q <= count_q - cw'(1);
            top_q   <= (count_q >= cw'(2)) ? rd_data : '0;
          end else begin
            unf_q <= 1'b1;
          end
        end
        CTRL_CLR: begin
          count_q <= '0;
          top_q   <= '0;
          ovf_q   <= 1'b0;
          unf_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.top   = top_q;
  assign bus.count = count_q;
  assign bus.empty = empty_w;
  assign bus.full  = full_w;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

// File: tb/tb_ret_stack.sv
// Directed bench for ret_stack (n=8, depth=4) with hand-computed expectations per step.
module tb_ret_stack;
  import proc_ctrl_pkg::*;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  ret_stack_if #(.n(8), .depth(4)) bus ();

  ret_stack #(.n(8), .depth(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then check every status output after the edge.
  task automatic step(input string tag, input logic c_clr, input logic [1:0] c_ctrl,
                      input logic [7:0] c_in, input logic [7:0] e_top,
                      input logic [2:0] e_cnt, input logic e_ovf, input logic e_unf);
    @(negedge clk);
    clr      = c_clr;
    bus.ctrl = c_ctrl;
    bus.in   = c_in;
    @(posedge clk);
    #1;
    chk({tag, ".top"},   32'(bus.top),   32'(e_top));
    chk({tag, ".count"}, 32'(bus.count), 32'(e_cnt));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(e_cnt == 3'd0));
    chk({tag, ".full"},  32'(bus.full),  32'(e_cnt == 3'd4));
    chk({tag, ".ovf"},   32'(bus.ovf),   32'(e_ovf));
    chk({tag, ".unf"},   32'(bus.unf),   32'(e_unf));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b1;
    bus.ctrl = CTRL_HOLD;
    bus.in   = 8'h00;

    // reset, then hold
    step("rst",   1, CTRL_HOLD, 8'h00, 8'h00, 3'd0, 0, 0);
    step("hold0", 0, CTRL_HOLD, 8'h00, 8'h00, 3'd0, 0, 0);
    step("hold1", 0, CTRL_HOLD, 8'h5A, 8'h00, 3'd0, 0, 0);
    step("hold2", 0, CTRL_HOLD, 8'h00, 8'h00, 3'd0, 0, 0);

    // fill
    step("push10", 0, CTRL_PUSH, 8'h10, 8'h10, 3'd1, 0, 0);
    step("push21", 0, CTRL_PUSH, 8'h21, 8'h21, 3'd2, 0, 0);
    step("push32", 0, CTRL_PUSH, 8'h32, 8'h32, 3'd3, 0, 0);
    step("push43", 0, CTRL_PUSH, 8'h43, 8'h43, 3'd4, 0, 0);
    step("holdfull", 0, CTRL_HOLD, 8'h00, 8'h43, 3'd4, 0, 0);

    // overflow: discarded, sticky flag set
    step("pushFF", 0, CTRL_PUSH, 8'hFF, 8'h43, 3'd4, 1, 0);

    // drain
    step("pop1", 0, CTRL_POP, 8'h00, 8'h32, 3'd3, 1, 0);
    step("pop2", 0, CTRL_POP, 8'h00, 8'h21, 3'd2, 1, 0);
    step("pop3", 0, CTRL_POP, 8'h00, 8'h10, 3'd1, 1, 0);
    step("pop4", 0, CTRL_POP, 8'h00, 8'h00, 3'd0, 1, 0);

    // underflow
    step("popempty", 0, CTRL_POP, 8'h00, 8'h00, 3'd0, 1, 1);
    step("clear0",   0, CTRL_CLR, 8'h00, 8'h00, 3'd0, 0, 0);
    step("popempty2",0, CTRL_POP, 8'h00, 8'h00, 3'd0, 0, 1);
    step("push05",   0, CTRL_PUSH, 8'h05, 8'h05, 3'd1, 0, 1);
    step("clear1",   0, CTRL_CLR, 8'h99, 8'h00, 3'd0, 0, 0);

    // interleave at full rate
    step("pushA0", 0, CTRL_PUSH, 8'hA0, 8'hA0, 3'd1, 0, 0);
    step("pushB1", 0, CTRL_PUSH, 8'hB1, 8'hB1, 3'd2, 0, 0);
    step("ipop1",  0, CTRL_POP,  8'h00, 8'hA0, 3'd1, 0, 0);
    step("pushC2", 0, CTRL_PUSH, 8'hC2, 8'hC2, 3'd2, 0, 0);
    step("ipop2",  0, CTRL_POP,  8'h00, 8'hA0, 3'd1, 0, 0);
    step("ipop3",  0, CTRL_POP,  8'h00, 8'h00, 3'd0, 0, 0);

    // ctrl=11 with count=3 and ovf=1
    step("f1", 0, CTRL_PUSH, 8'h01, 8'h01, 3'd1, 0, 0);
    step("f2", 0, CTRL_PUSH, 8'h02, 8'h02, 3'd2, 0, 0);
    step("f3", 0, CTRL_PUSH, 8'h03, 8'h03, 3'd3, 0, 0);
    step("f4", 0, CTRL_PUSH, 8'h04, 8'h04, 3'd4, 0, 0);
    step("fovf", 0, CTRL_PUSH, 8'hEE, 8'h04, 3'd4, 1, 0);
    step("fpop", 0, CTRL_POP,  8'h00, 8'h03, 3'd3, 1, 0);
    step("fclr", 0, CTRL_CLR,  8'h00, 8'h00, 3'd0, 0, 0);

    // clr wins over a concurrent push
    step("g1", 0, CTRL_PUSH, 8'h11, 8'h11, 3'd1, 0, 0);
    step("g2", 0, CTRL_PUSH, 8'h22, 8'h22, 3'd2, 0, 0);
    step("gunf_setup", 0, CTRL_PUSH, 8'h33, 8'h33, 3'd3, 0, 0);
    step("grst", 1, CTRL_PUSH, 8'h77, 8'h00, 3'd0, 0, 0);
    step("g77",  0, CTRL_PUSH, 8'h77, 8'h77, 3'd1, 0, 0);
    step("gpop", 0, CTRL_POP,  8'h00, 8'h00, 3'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
